link_anim_sequencer: RTL and testbench

- Sequences the player sprite's animation and selects which sprite image and palette the renderer uses on the current frame.
- Takes direction keys and an attack request; runs three states: idle, walking (2-frame walk cycle) and a sword attack (4-frame swing).
- Advances frames on a once-per-frame tick (vsync-derived) and emits a 5-bit sprite code.
- The sprite code drives the ROM mux and the per-sprite palette mux in the colour mapper.

---
 rtl/link_anim_sequencer_pkg.sv | 35 +++
 rtl/link_anim_sequencer_if.sv | 28 ++
 rtl/link_anim_sequencer_anim_tick_div.sv | 32 +++
 rtl/link_anim_sequencer.sv | 120 ++++++++++++
 tb/tb_link_anim_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/link_anim_sequencer_pkg.sv
// Shared types and sprite-code constants for the player animation sequencer.
`default_nettype none

package zelda_anim_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_ATTACK = 2'd2
  } state_t;

  localparam int WALK_FRAMES = 2;
  localparam int ATK_FRAMES  = 4;

  localparam logic [4:0] SPR_WALK_DOWN_0   = 5'b00000;
  localparam logic [4:0] SPR_WALK_RIGHT_0  = 5'b01100;
  localparam logic [4:0] SPR_SWORD_DOWN_0  = 5'b10000;
  localparam logic [4:0] SPR_SWORD_RIGHT_3 = 5'b11111;

  // Sprite code layout consumed by the ROM and palette muxes.
  function automatic logic [4:0] sprite_code(input logic atk, input dir_t d,
                                             input logic [1:0] f);
    return {atk, d, f};
  endfunction

endpackage

`default_nettype wire

// File: rtl/link_anim_sequencer_if.sv
// Key/attack inputs and sprite-selection outputs of the animation sequencer.
`default_nettype none

interface link_anim_if;
  logic       frame_tick;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
  logic       attack_req;
  logic [4:0] sprite_sel;
  logic [1:0] dir;
  logic       moving;
  logic       attacking;
  logic       attack_done;

  modport master (
    output frame_tick, key_up, key_down, key_left, key_right, attack_req,
    input  sprite_sel, dir, moving, attacking, attack_done
  );

  modport slave (
    input  frame_tick, key_up, key_down, key_left, key_right, attack_req,
    output sprite_sel, dir, moving, attacking, attack_done
  );
endinterface

`default_nettype wire

// File: rtl/link_anim_sequencer_anim_tick_div.sv
// Frame-tick divider: pulses advance on the tick that completes div ticks.
`default_nettype none

module anim_tick_div #(
  parameter int W = 8
) (
  input  wire logic         Clk,
  input  wire logic         Reset_n,
  input  wire logic         clear,
  input  wire logic         tick,
  input  wire logic [W-1:0] div,
  output logic              advance
);

  logic [W-1:0] cnt;
  logic         at_end;

  assign at_end  = (cnt == div - W'(1));
  // A tick in a clearing cycle is consumed, never turned into an advance.
  assign advance = tick & at_end & ~clear;

  always_ff @(posedge Clk) begin
    if (!Reset_n || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= at_end ? '0 : cnt + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/link_anim_sequencer.sv
// Player sprite animation FSM: idle / 2-frame walk / 4-frame sword swing.
`default_nettype none

module link_anim_sequencer
  import zelda_anim_pkg::*;
#(
  parameter int unsigned WALK_DIV = 8,
  parameter int unsigned ATK_DIV  = 4
) (
  input  wire logic  Clk,
  input  wire logic  Reset_n,
  link_anim_if.slave bus
);

  localparam logic [1:0] LAST_ATK_FRAME = 2'(ATK_FRAMES - 1);

  state_t     state, state_n;
  dir_t       dir_q, dir_n, key_dir;
  logic [1:0] frame, frame_n;
  logic       key_any, clear, advance, done_n;
  logic       moving_q, attacking_q, done_q;
  logic [7:0] div_sel;

  assign div_sel = (state == ST_ATTACK) ? 8'(ATK_DIV) : 8'(WALK_DIV);

  anim_tick_div #(.W(8)) u_div (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (clear),
    .tick    (bus.frame_tick),
    .div     (div_sel),
    .advance (advance)
  );

  always_comb begin
    key_any = bus.key_up | bus.key_down | bus.key_left | bus.key_right;
    key_dir = DIR_RIGHT;
    if (bus.key_up)        key_dir = DIR_UP;
    else if (bus.key_down) key_dir = DIR_DOWN;
    else if (bus.key_left) key_dir = DIR_LEFT;
  end

  always_comb begin
    state_n = state;
    dir_n   = dir_q;
    frame_n = frame;
    clear   = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        frame_n = 2'd0;
        clear   = 1'b1;
        if (bus.attack_req) begin
          state_n = ST_ATTACK;
        end else if (key_any) begin
          state_n = ST_WALK;
          dir_n   = key_dir;
        end
      end
      ST_WALK: begin
        if (bus.attack_req) begin
          state_n = ST_ATTACK;
          frame_n = 2'd0;
          clear   = 1'b1;
        end else if (!key_any) begin
          state_n = ST_IDLE;
          frame_n = 2'd0;
          clear   = 1'b1;
        end else begin
          dir_n = key_dir;
          if (advance) frame_n = {1'b0, ~frame[0]};
        end
      end
      ST_ATTACK: begin
        // Keys and new attack requests are deliberately ignored mid-swing.
        if (advance) begin
          if (frame == LAST_ATK_FRAME) begin
            state_n = ST_IDLE;
            frame_n = 2'd0;
            done_n  = 1'b1;
          end else begin
            frame_n = frame + 2'd1;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        frame_n = 2'd0;
        clear   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      dir_q       <= DIR_DOWN;
      frame       <= 2'd0;
      moving_q    <= 1'b0;
      attacking_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      dir_q       <= dir_n;
      frame       <= frame_n;
      moving_q    <= (state_n == ST_WALK);
      attacking_q <= (state_n == ST_ATTACK);
      done_q      <= done_n;
    end
  end

  assign bus.sprite_sel  = sprite_code(attacking_q, dir_q, frame);
  assign bus.dir         = dir_q;
  assign bus.moving      = moving_q;
  assign bus.attacking   = attacking_q;
  assign bus.attack_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_link_anim_sequencer.sv
// Directed self-checking bench: dut_a (WALK_DIV=2, ATK_DIV=1), dut_b (ATK_DIV=3).
`default_nettype none

module tb_link_anim_sequencer;

  logic Clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;

  always #5 Clk = ~Clk;

  link_anim_if ifa ();
  link_anim_if ifb ();

  link_anim_sequencer #(.WALK_DIV(2), .ATK_DIV(1)) dut_a (
    .Clk (Clk), .Reset_n (rst_a_n), .bus (ifa)
  );

  link_anim_sequencer #(.WALK_DIV(2), .ATK_DIV(3)) dut_b (
    .Clk (Clk), .Reset_n (rst_b_n), .bus (ifb)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [4:0] spr, input logic mv,
                       input logic atk, input logic dn);
    chk({tag, ".spr"}, 8'(ifa.sprite_sel), 8'(spr));
    chk({tag, ".mov"}, 8'(ifa.moving), 8'(mv));
    chk({tag, ".atk"}, 8'(ifa.attacking), 8'(atk));
    chk({tag, ".done"}, 8'(ifa.attack_done), 8'(dn));
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick_a();
    ifa.frame_tick = 1'b1;
    step();
    ifa.frame_tick = 1'b0;
  endtask

  task automatic tick_b();
    ifb.frame_tick = 1'b1;
    step();
    ifb.frame_tick = 1'b0;
  endtask

  initial begin
    {ifa.frame_tick, ifa.key_up, ifa.key_down, ifa.key_left, ifa.key_right, ifa.attack_req} = '0;
    {ifb.frame_tick, ifb.key_up, ifb.key_down, ifb.key_left, ifb.key_right, ifb.attack_req} = '0;

    // 1. Reset with keys toggling
    ifa.key_right = 1'b1;
    ifa.attack_req = 1'b1;
    step();
    ifa.key_right = 1'b0;
    ifa.key_up = 1'b1;
    step();
    chk_a("reset", 5'b00000, 1'b0, 1'b0, 1'b0);
    chk("reset.dir", 8'(ifa.dir), 8'd0);
    ifa.key_up = 1'b0;
    ifa.attack_req = 1'b0;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    step();
    chk_a("post_reset", 5'b00000, 1'b0, 1'b0, 1'b0);

    // 2. Walk right, four ticks
    ifa.key_right = 1'b1;
    step();
    chk_a("walk_r.enter", 5'b01100, 1'b1, 1'b0, 1'b0);
    chk("walk_r.dir", 8'(ifa.dir), 8'd3);
    tick_a();
    chk("walk_r.t1", 8'(ifa.sprite_sel), 8'b01100);
    tick_a();
    chk("walk_r.t2", 8'(ifa.sprite_sel), 8'b01101);
    tick_a();
    chk("walk_r.t3", 8'(ifa.sprite_sel), 8'b01101);
    tick_a();
    chk("walk_r.t4", 8'(ifa.sprite_sel), 8'b01100);
    ifa.key_right = 1'b0;
    step();
    chk_a("walk_r.release", 5'b01100, 1'b0, 1'b0, 1'b0);

    // 3. Up+left priority, direction change mid-walk, tick on release
    ifa.key_up = 1'b1;
    ifa.key_left = 1'b1;
    step();
    chk_a("ul.enter", 5'b00100, 1'b1, 1'b0, 1'b0);
    tick_a();
    tick_a();
    chk("ul.frame1", 8'(ifa.sprite_sel), 8'b00101);
    tick_a();
    ifa.key_up = 1'b0;
    step();
    chk("dirchg.keep_frame", 8'(ifa.sprite_sel), 8'b01001);
    tick_a();
    chk("dirchg.cnt_continues", 8'(ifa.sprite_sel), 8'b01000);
    tick_a();
    tick_a();
    chk("left.frame1", 8'(ifa.sprite_sel), 8'b01001);
    tick_a();
    ifa.key_left = 1'b0;
    tick_a();
    chk_a("release_tick", 5'b01000, 1'b0, 1'b0, 1'b0);
    ifa.key_left = 1'b1;
    step();
    tick_a();
    chk("rewalk.cnt_cleared", 8'(ifa.sprite_sel), 8'b01000);
    ifa.key_left = 1'b0;
    step();

    // 4. Sword swing facing left
    ifa.attack_req = 1'b1;
    step();
    ifa.attack_req = 1'b0;
    chk_a("atk.enter", 5'b11000, 1'b0, 1'b1, 1'b0);
    tick_a();
    chk_a("atk.f1", 5'b11001, 1'b0, 1'b1, 1'b0);
    tick_a();
    chk_a("atk.f2", 5'b11010, 1'b0, 1'b1, 1'b0);
    tick_a();
    chk_a("atk.f3", 5'b11011, 1'b0, 1'b1, 1'b0);
    tick_a();
    chk_a("atk.done", 5'b01000, 1'b0, 1'b0, 1'b1);
    step();
    chk_a("atk.after", 5'b01000, 1'b0, 1'b0, 1'b0);

    // 5. Ignored keys/requests during swing, reset aborts it
    ifa.attack_req = 1'b1;
    step();
    ifa.attack_req = 1'b0;
    ifa.key_up = 1'b1;
    tick_a();
    ifa.attack_req = 1'b1;
    chk_a("ign.f1", 5'b11001, 1'b0, 1'b1, 1'b0);
    tick_a();
    chk_a("ign.f2", 5'b11010, 1'b0, 1'b1, 1'b0);
    rst_a_n = 1'b0;
    tick_a();
    chk_a("abort.rst", 5'b00000, 1'b0, 1'b0, 1'b0);
    ifa.key_up = 1'b0;
    ifa.attack_req = 1'b0;
    step();
    rst_a_n = 1'b1;
    step();
    chk_a("abort.idle", 5'b00000, 1'b0, 1'b0, 1'b0);

    // 6. Held attack on ATK_DIV=3 instance: back-to-back swings
    ifb.attack_req = 1'b1;
    step();
    chk("hold.enter", 8'(ifb.sprite_sel), 8'b10000);
    for (int s = 0; s < 2; s++) begin
      for (int k = 1; k <= 12; k++) begin
        tick_b();
        if (ifb.attack_done) dones++;
        if (k < 12) begin
          chk($sformatf("hold.s%0d.k%0d", s, k), 8'(ifb.sprite_sel), {5'b00010, 1'b0, 2'(k / 3)});
          chk($sformatf("hold.s%0d.k%0d.done", s, k), 8'(ifb.attack_done), 8'd0);
        end else begin
          chk($sformatf("hold.s%0d.done", s), 8'(ifb.attack_done), 8'd1);
          chk($sformatf("hold.s%0d.atk", s), 8'(ifb.attacking), 8'd0);
        end
      end
      step();
      chk($sformatf("hold.s%0d.restart", s), 8'(ifb.sprite_sel), 8'b10000);
      chk($sformatf("hold.s%0d.restart_done", s), 8'(ifb.attack_done), 8'd0);
    end
    chk("hold.done_count", 8'(dones), 8'd2);
    ifb.attack_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
